// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler: FSM states, key mode,
// client id and the 128/256-bit data types.
package aes_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEY_ISSUE,
        KEY_WAIT,
        DATA_WAIT_RDY,
        DATA_ISSUE,
        DATA_WAIT,
        RESP
    } sched_state_e;

    localparam logic [1:0] KEY_MODE_256 = 2'b10;
    localparam int         NUM_CLIENTS  = 2;

    typedef logic         client_id_t;
    typedef logic [127:0] u128_t;
    typedef logic [255:0] u256_t;

    function automatic logic [NUM_CLIENTS-1:0] id2onehot(input client_id_t id);
        return 2'b01 << id;
    endfunction

endpackage

// File: rtl/aes_job_scheduler_if.sv
// Client-side (key load, job request/response) and core-side bundles of the
// AES job scheduler. The scheduler is the slave of the client bus and the
// master of the core bus.
interface aes_job_scheduler_if;
    import aes_sched_pkg::*;

    logic                   key_valid;
    u256_t                  key_in;
    logic                   key_ready;
    logic [1:0]             req_valid;
    logic [1:0]             req_ende;
    logic [1:0][127:0]      req_data;
    logic [1:0]             req_ready;
    logic [1:0]             resp_valid;
    u128_t                  resp_data;
    logic                   resp_err;

    modport slave (
        input  key_valid, key_in, req_valid, req_ende, req_data,
        output key_ready, req_ready, resp_valid, resp_data, resp_err
    );

    modport master (
        output key_valid, key_in, req_valid, req_ende, req_data,
        input  key_ready, req_ready, resp_valid, resp_data, resp_err
    );
endinterface

interface aes_core_if;
    import aes_sched_pkg::*;

    u256_t       i_key;
    logic [1:0]  i_key_mode;
    logic        i_start;
    logic        o_key_ready;
    u128_t       i_data;
    logic        i_data_valid;
    logic        i_ende;
    logic        i_enable;
    logic        o_ready;
    logic        o_data_valid;
    u128_t       o_data;

    modport master (
        output i_key, i_key_mode, i_start, i_data, i_data_valid, i_ende, i_enable,
        input  o_key_ready, o_ready, o_data_valid, o_data
    );

    modport slave (
        input  i_key, i_key_mode, i_start, i_data, i_data_valid, i_ende, i_enable,
        output o_key_ready, o_ready, o_data_valid, o_data
    );
endinterface

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter; priority passes to the other client only when
// a grant is actually issued.
module aes_rr_arb2
    import aes_sched_pkg::*;
(
    input  logic       clk,
    input  logic       resetH,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output client_id_t gnt_id
);

    client_id_t prio_q, prio_d;

    always_comb begin
        gnt_id = req[prio_q] ? prio_q : ~prio_q;
        gnt    = (en && req[gnt_id]) ? id2onehot(gnt_id) : 2'b00;
        prio_d = (|gnt) ? ~gnt_id : prio_q;
    end

    always_ff @(posedge clk) begin
        if (resetH) prio_q <= 1'b0;
        else        prio_q <= prio_d;
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// Serialises key loads and two clients' AES jobs onto a single AES core.
// Define AES_SCHED_TIMEOUT_EN to bound KEY_WAIT/DATA_WAIT by TIMEOUT_CYCLES.
module aes_job_scheduler
    import aes_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  resetH,
    aes_job_scheduler_if.slave    cli,
    aes_core_if.master            core
);

    sched_state_e state_q, state_d;
    logic         key_loaded_q, key_loaded_d;
    logic         first_q, first_d;
    u256_t        key_q, key_d;
    logic [1:0]   key_mode_q, key_mode_d;
    u128_t        data_q, data_d;
    logic         ende_q, ende_d;
    client_id_t   id_q, id_d;
    logic         key_ready_q, key_ready_d;
    logic [1:0]   req_ready_q, req_ready_d;
    logic [1:0]   resp_valid_q, resp_valid_d;
    u128_t        resp_data_q, resp_data_d;
    logic         start_q, start_d;
    logic         dvalid_q, dvalid_d;
    logic         enable_q, enable_d;

    logic [1:0]   gnt;
    client_id_t   gnt_id;
    logic         arb_en;

`ifdef AES_SCHED_TIMEOUT_EN
    logic [31:0]  cnt_q, cnt_d;
    logic         resp_err_q, resp_err_d;
    logic         timeout;

    assign timeout = (cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
    logic         unused_cfg;

    assign unused_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    // Jobs are only granted in IDLE, with a key loaded and no pending key request.
    assign arb_en = (state_q == IDLE) && key_loaded_q && !cli.key_valid;

    aes_rr_arb2 u_arb (
        .clk    (clk),
        .resetH (resetH),
        .en     (arb_en),
        .req    (cli.req_valid),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        state_d      = state_q;
        key_loaded_d = key_loaded_q;
        first_d      = first_q;
        key_d        = key_q;
        key_mode_d   = key_mode_q;
        data_d       = data_q;
        ende_d       = ende_q;
        id_d         = id_q;
        key_ready_d  = 1'b0;
        req_ready_d  = 2'b00;
        resp_valid_d = 2'b00;
        resp_data_d  = '0;
`ifdef AES_SCHED_TIMEOUT_EN
        resp_err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (cli.key_valid) begin
                    key_d       = cli.key_in;
                    key_mode_d  = KEY_MODE_256;
                    key_ready_d = 1'b1;
                    state_d     = KEY_ISSUE;
                end else if (|gnt) begin
                    req_ready_d = gnt;
                    data_d      = cli.req_data[gnt_id];
                    ende_d      = cli.req_ende[gnt_id];
                    id_d        = gnt_id;
                    state_d     = DATA_WAIT_RDY;
                end
            end
            KEY_ISSUE: begin
                first_d = 1'b1;
                state_d = KEY_WAIT;
            end
            KEY_WAIT: begin
                first_d = 1'b0;
                // The core may still show stale status right after i_start.
                if (!first_q && core.o_key_ready) begin
                    key_loaded_d = 1'b1;
                    state_d      = IDLE;
                end
`ifdef AES_SCHED_TIMEOUT_EN
                else if (timeout) begin
                    key_loaded_d = 1'b0;
                    state_d      = IDLE;
                end
`endif
            end
            DATA_WAIT_RDY: begin
                if (core.o_ready) state_d = DATA_ISSUE;
            end
            DATA_ISSUE: begin
                first_d = 1'b1;
                state_d = DATA_WAIT;
            end
            DATA_WAIT: begin
                first_d = 1'b0;
                if (!first_q && core.o_data_valid) begin
                    resp_data_d  = core.o_data;
                    resp_valid_d = id2onehot(id_q);
                    state_d      = RESP;
                end
`ifdef AES_SCHED_TIMEOUT_EN
                else if (timeout) begin
                    resp_valid_d = id2onehot(id_q);
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Core strobes are registered from the next state so they line up with it.
        start_d  = (state_d == KEY_ISSUE);
        dvalid_d = (state_d == DATA_ISSUE);
        enable_d = (state_d == DATA_ISSUE) || (state_d == DATA_WAIT);
    end

`ifdef AES_SCHED_TIMEOUT_EN
    always_comb begin
        cnt_d = '0;
        if ((state_q == KEY_WAIT || state_q == DATA_WAIT) && state_d == state_q)
            cnt_d = cnt_q + 32'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (resetH) begin
            state_q      <= IDLE;
            key_loaded_q <= 1'b0;
            first_q      <= 1'b0;
            key_q        <= '0;
            key_mode_q   <= 2'b00;
            data_q       <= '0;
            ende_q       <= 1'b0;
            id_q         <= 1'b0;
            key_ready_q  <= 1'b0;
            req_ready_q  <= 2'b00;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
            start_q      <= 1'b0;
            dvalid_q     <= 1'b0;
            enable_q     <= 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
            cnt_q        <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            key_loaded_q <= key_loaded_d;
            first_q      <= first_d;
            key_q        <= key_d;
            key_mode_q   <= key_mode_d;
            data_q       <= data_d;
            ende_q       <= ende_d;
            id_q         <= id_d;
            key_ready_q  <= key_ready_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            start_q      <= start_d;
            dvalid_q     <= dvalid_d;
            enable_q     <= enable_d;
`ifdef AES_SCHED_TIMEOUT_EN
            cnt_q        <= cnt_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign cli.key_ready    = key_ready_q;
    assign cli.req_ready    = req_ready_q;
    assign cli.resp_valid   = resp_valid_q;
    assign cli.resp_data    = resp_data_q;
`ifdef AES_SCHED_TIMEOUT_EN
    assign cli.resp_err     = resp_err_q;
`else
    assign cli.resp_err     = 1'b0;
`endif
    assign core.i_key        = key_q;
    assign core.i_key_mode   = key_mode_q;
    assign core.i_start      = start_q;
    assign core.i_data       = data_q;
    assign core.i_data_valid = dvalid_q;
    assign core.i_ende       = ende_q;
    assign core.i_enable     = enable_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Bench for aes_job_scheduler: stub AES core, two client drivers and a
// response scoreboard.
module tb_aes_job_scheduler;

    localparam int KEY_LAT  = 4;
    localparam int DATA_LAT = 3;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        int           cid;
        logic [127:0] dat;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic resetH = 1'b1;
    always #5 clk = ~clk;

    aes_job_scheduler_if cli_if ();
    aes_core_if          core_if ();

    aes_job_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .clk    (clk),
        .resetH (resetH),
        .cli    (cli_if),
        .core   (core_if)
    );

    int checks = 0;
    int failures = 0;
    int rsp_cnt = 0;
    time rsp_time = 0;
    time kr_time = 0;
    exp_t sb[$];
    int gorder[$];
    logic [255:0] loaded_key = '0;

    logic         cv[2];
    logic [127:0] cd[2];
    logic         ce[2];
    assign cli_if.req_valid = {cv[1], cv[0]};
    assign cli_if.req_data  = {cd[1], cd[0]};
    assign cli_if.req_ende  = {ce[1], ce[0]};

    // Stub core: FIPS-197 vector for the known pair, a keyed XOR otherwise.
    function automatic logic [127:0] stub(input logic [255:0] k, input logic [127:0] d, input logic e);
        if (k == FIPS_KEY && d == FIPS_PT && !e) return FIPS_CT;
        return d ^ k[127:0] ^ k[255:128] ^ {128{e}};
    endfunction

    logic         core_rdy = 1'b1;
    logic         core_hang = 1'b0;
    logic [255:0] ckey;
    logic [127:0] cdata;
    int           kcnt, dcnt;
    assign core_if.o_ready = core_rdy;

    always @(posedge clk) begin
        core_if.o_key_ready  <= 1'b0;
        core_if.o_data_valid <= 1'b0;
        if (resetH) begin
            kcnt <= 0;
            dcnt <= 0;
        end else begin
            if (core_if.i_start) begin
                ckey <= core_if.i_key;
                kcnt <= KEY_LAT;
            end else if (kcnt != 0) begin
                kcnt <= kcnt - 1;
                if (kcnt == 1) core_if.o_key_ready <= 1'b1;
            end
            if (core_if.i_data_valid && !core_hang) begin
                cdata <= stub(ckey, core_if.i_data, core_if.i_ende);
                dcnt  <= DATA_LAT;
            end else if (dcnt != 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1) begin
                    core_if.o_data_valid <= 1'b1;
                    core_if.o_data       <= cdata;
                end
            end
        end
    end

    // Scoreboard pop and core strobe spacing monitor.
    exp_t mon_e;
    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (cli_if.resp_valid !== 2'b00) begin
            checks++;
            rsp_cnt++;
            rsp_time = $time;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected got_valid=%b exp=none", cli_if.resp_valid);
            end else begin
                mon_e = sb.pop_front();
                if (cli_if.resp_valid !== (2'b01 << mon_e.cid) || cli_if.resp_data !== mon_e.dat ||
                    cli_if.resp_err !== mon_e.err) begin
                    failures++;
                    $display("FAIL resp got v=%b d=%h e=%b exp v=%b d=%h e=%b", cli_if.resp_valid,
                             cli_if.resp_data, cli_if.resp_err, 2'b01 << mon_e.cid, mon_e.dat, mon_e.err);
                end
            end
        end
        if (core_if.i_start || core_if.i_data_valid) begin
            checks++;
            if ((core_if.i_start && core_if.i_data_valid) || prev_strobe) begin
                failures++;
                $display("FAIL strobe_spacing start=%b dv=%b prev=%b exp isolated", core_if.i_start,
                         core_if.i_data_valid, prev_strobe);
            end
        end
        prev_strobe = core_if.i_start || core_if.i_data_valid;
    end

    task automatic submit(input int c, input logic [127:0] d, input logic e, input logic err,
                          input int bound, output bit granted);
        exp_t x;
        cd[c] = d;
        ce[c] = e;
        cv[c] = 1'b1;
        granted = 1'b0;
        for (int i = 0; i < bound && !granted; i++) begin
            @(negedge clk);
            if (cli_if.req_ready[c]) begin
                granted = 1'b1;
                x.cid = c;
                x.dat = err ? 128'd0 : stub(loaded_key, d, e);
                x.err = err;
                sb.push_back(x);
                gorder.push_back(c);
            end
        end
        cv[c] = 1'b0;
    endtask

    task automatic load_key(input logic [255:0] k);
        bit seen = 1'b0;
        cli_if.key_in    = k;
        cli_if.key_valid = 1'b1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (cli_if.key_ready) seen = 1'b1;
        end
        cli_if.key_valid = 1'b0;
        kr_time = $time;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL key_ready_timeout got=0 exp=1");
        end else begin
            checks++;
            if (core_if.i_start !== 1'b1 || core_if.i_key !== k || core_if.i_key_mode !== 2'b10) begin
                failures++;
                $display("FAIL key_issue got start=%b mode=%b key=%h exp start=1 mode=10 key=%h",
                         core_if.i_start, core_if.i_key_mode, core_if.i_key, k);
            end
        end
        loaded_key = k;
        repeat (KEY_LAT + 4) @(negedge clk);
    endtask

    task automatic wait_resp(input int target, input string name);
        int i = 0;
        while (rsp_cnt < target && i < 400) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (rsp_cnt < target) begin
            failures++;
            $display("FAIL %s resp_count got=%0d exp=%0d", name, rsp_cnt, target);
        end
    endtask

    task automatic wait_dv(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (core_if.i_data_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL data_issue_timeout got=0 exp=1");
        end
    endtask

    task automatic check_outputs_zero(input string name);
        logic [12:0] ctrl;
        ctrl = {cli_if.key_ready, cli_if.req_ready, cli_if.resp_valid, cli_if.resp_err,
                core_if.i_start, core_if.i_data_valid, core_if.i_enable, core_if.i_ende, core_if.i_key_mode};
        checks++;
        if (ctrl !== '0) begin
            failures++;
            $display("FAIL %s_ctrl got=%b exp=0", name, ctrl);
        end
        checks++;
        if (cli_if.resp_data !== '0 || core_if.i_key !== '0 || core_if.i_data !== '0) begin
            failures++;
            $display("FAIL %s_data got rd=%h key=%h d=%h exp=0", name, cli_if.resp_data, core_if.i_key,
                     core_if.i_data);
        end
    endtask

    task automatic test_reset();
        cli_if.key_valid = 1'b0;
        cli_if.key_in    = '0;
        for (int c = 0; c < 2; c++) begin
            cv[c] = 1'b0;
            cd[c] = '0;
            ce[c] = 1'b0;
        end
        resetH = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        resetH = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_key_then_fips();
        bit g;
        submit(0, FIPS_PT, 1'b0, 1'b0, 20, g);
        checks++;
        if (g) begin
            failures++;
            $display("FAIL no_key_grant got=1 exp=0");
        end
        load_key(FIPS_KEY);
        submit(0, FIPS_PT, 1'b0, 1'b0, 20, g);
        checks++;
        if (!g) begin
            failures++;
            $display("FAIL fips_grant got=0 exp=1");
        end
        wait_resp(rsp_cnt + 1, "fips");
        submit(1, 128'h0123456789abcdef0011223344556677, 1'b1, 1'b0, 20, g);
        checks++;
        if (!g) begin
            failures++;
            $display("FAIL decrypt_grant got=0 exp=1");
        end
        wait_resp(rsp_cnt + 1, "decrypt");
    endtask

    task automatic test_back_to_back();
        int base = rsp_cnt;
        bit g0 = 1'b1, g1 = 1'b1;
        gorder.delete();
        fork
            for (int j = 0; j < 3; j++) begin
                bit g;
                submit(0, {$urandom, $urandom, $urandom, $urandom}, j[0], 1'b0, 100, g);
                g0 &= g;
            end
            for (int j = 0; j < 3; j++) begin
                bit g;
                submit(1, {$urandom, $urandom, $urandom, $urandom}, ~j[0], 1'b0, 100, g);
                g1 &= g;
            end
        join
        wait_resp(base + 6, "b2b");
        checks++;
        if (!(g0 && g1) || gorder.size() != 6) begin
            failures++;
            $display("FAIL b2b_grants got=%0d exp=6", gorder.size());
        end
        for (int i = 1; i < gorder.size(); i++) begin
            checks++;
            if (gorder[i] == gorder[i-1]) begin
                failures++;
                $display("FAIL b2b_alternate idx=%0d got=%0d exp=%0d", i, gorder[i], 1 - gorder[i-1]);
            end
        end
    endtask

    task automatic test_key_mid_job();
        bit g, f;
        int base = rsp_cnt;
        core_rdy = 1'b0;
        submit(0, 128'hfeedface_cafebabe_01234567_89abcdef, 1'b0, 1'b0, 20, g);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (core_if.i_data_valid !== 1'b0) begin
                failures++;
                $display("FAIL wait_rdy_issue got=%b exp=0", core_if.i_data_valid);
            end
        end
        core_rdy = 1'b1;
        wait_dv(f);
        load_key(256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
        checks++;
        if (rsp_cnt != base + 1 || kr_time <= rsp_time) begin
            failures++;
            $display("FAIL key_after_resp got rsp=%0d kr_t=%0t rsp_t=%0t exp rsp=%0d kr_t>rsp_t", rsp_cnt - base,
                     kr_time, rsp_time, 1);
        end
        submit(1, 128'h55aa55aa_00ff00ff_12345678_9abcdef0, 1'b0, 1'b0, 20, g);
        wait_resp(base + 2, "new_key_job");
    endtask

    task automatic test_reset_mid_job();
        bit g, f;
        int base;
        core_hang = 1'b1;
        submit(1, 128'h11112222333344445555666677778888, 1'b0, 1'b0, 20, g);
        wait_dv(f);
        repeat (2) @(negedge clk);
        resetH = 1'b1;
        sb.delete();
        @(negedge clk);
        resetH = 1'b0;
        check_outputs_zero("reset_mid");
        core_hang = 1'b0;
        base = rsp_cnt;
        submit(0, 128'h99990000aaaabbbbccccddddeeeeffff, 1'b0, 1'b0, 20, g);
        checks++;
        if (g || rsp_cnt != base) begin
            failures++;
            $display("FAIL reset_mid_no_key got grant=%b rsp=%0d exp grant=0 rsp=0", g, rsp_cnt - base);
        end
        load_key(FIPS_KEY);
        submit(0, FIPS_PT, 1'b0, 1'b0, 20, g);
        checks++;
        if (!g) begin
            failures++;
            $display("FAIL reset_mid_regrant got=0 exp=1");
        end
        wait_resp(base + 1, "reset_mid_job");
    endtask

`ifdef AES_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit g, f;
        int n = 0;
        core_hang = 1'b1;
        submit(1, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, 1'b0, 1'b1, 20, g);
        wait_dv(f);
        while (cli_if.resp_valid === 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 17) begin
            failures++;
            $display("FAIL timeout_latency got=%0d exp=17", n);
        end
        core_hang = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_no_key_then_fips();
        test_back_to_back();
        test_key_mid_job();
`ifdef AES_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_job();
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
